// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    WAIT_INSTR = 3'd1,
    EXECUTE    = 3'd2,
    WAIT_MEM   = 3'd3,
    HALT       = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/core_next_pc.sv
// Combinational next-PC select: JAL, JALR, taken branch, else sequential; result is word aligned.
module core_next_pc
  import core_ctrl_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic        is_branch_i,
  input  logic        take_branch_i,
  input  logic [31:0] jimm_i,
  input  logic [31:0] bimm_i,
  input  logic [31:0] jalr_target_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] raw;

  always_comb begin
    raw = pc_i + PC_STEP;
    if (is_jal_i) begin
      raw = pc_i + jimm_i;
    end else if (is_jalr_i) begin
      raw = jalr_target_i;
    end else if (is_branch_i && take_branch_i) begin
      raw = pc_i + bimm_i;
    end
    next_pc_o = raw & 32'hFFFF_FFFC;
  end

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle RV32I sequencer: owns PC/IR, drives the instruction BRAM and
// steps each instruction through fetch, execute, optional memory wait and retire.
module core_control_fsm
  import core_ctrl_pkg::*;
#(
  parameter int          IMEM_AWIDTH = 7,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   isALUreg,
  input  logic                   isALUimm,
  input  logic                   isBranch,
  input  logic                   isJALR,
  input  logic                   isJAL,
  input  logic                   isAUIPC,
  input  logic                   isLUI,
  input  logic                   isLoad,
  input  logic                   isStore,
  input  logic                   isSYSTEM,
  input  logic [4:0]             rdId,
  input  logic [31:0]            Bimm,
  input  logic [31:0]            Jimm,
  input  logic [31:0]            jalr_target,
  input  logic                   take_branch,
  input  logic                   mem_ready,
  input  logic [31:0]            instr_data,
  output logic                   instr_read_enable,
  output logic [IMEM_AWIDTH-1:0] instr_addr,
  output logic [31:0]            ir,
  output logic [31:0]            pc,
  output logic                   rf_write_enable,
  output logic [1:0]             wb_sel,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   halted,
  output logic [31:0]            instret,
  output logic [2:0]             state
);

  ctrl_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] next_pc;
  logic        retire;
  logic        writes_rd;
  wb_sel_t     wb_sel_c;

  core_next_pc u_next_pc (
    .pc_i          (pc_q),
    .is_jal_i      (isJAL),
    .is_jalr_i     (isJALR),
    .is_branch_i   (isBranch),
    .take_branch_i (take_branch),
    .jimm_i        (Jimm),
    .bimm_i        (Bimm),
    .jalr_target_i (jalr_target),
    .next_pc_o     (next_pc)
  );

  assign writes_rd = isALUreg | isALUimm | isLUI | isAUIPC | isJAL | isJALR;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    instret_d       = instret_q;
    retire          = 1'b0;
    rf_write_enable = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    wb_sel_c        = WB_ALU;
    unique case (state_q)
      FETCH: state_d = WAIT_INSTR;
      WAIT_INSTR: begin
        ir_d    = instr_data;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (isLoad || isStore) begin
          mem_req = 1'b1;
          mem_we  = isStore;
          state_d = WAIT_MEM;
        end else if (isSYSTEM) begin
          state_d = HALT;
        end else begin
          // Branches and undecodable words fall through here and retire as NOPs.
          retire          = 1'b1;
          rf_write_enable = writes_rd && (rdId != 5'd0);
          if (isLUI) begin
            wb_sel_c = WB_IMM;
          end else if (isJAL || isJALR) begin
            wb_sel_c = WB_PC4;
          end
        end
      end
      WAIT_MEM: begin
        wb_sel_c = WB_MEM;
        if (mem_ready) begin
          retire          = 1'b1;
          rf_write_enable = isLoad && (rdId != 5'd0);
        end
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
    if (retire) begin
      state_d   = FETCH;
      pc_d      = next_pc;
      instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
    end
  end

  // Read enable is masked while reset is held so every strobe is quiet in reset.
  assign instr_read_enable = (state_q == FETCH) && !reset;
  assign instr_addr        = pc_q[IMEM_AWIDTH+1:2];
  assign ir                = ir_q;
  assign pc                = pc_q;
  assign instret           = instret_q;
  assign halted            = (state_q == HALT);
  assign wb_sel            = wb_sel_c;
  assign state             = state_q;

endmodule

// File: tb/tb_core_control_fsm.sv
// Bench for core_control_fsm: instruction-level schedule model, BRAM and decoder stand-ins.
module tb_core_control_fsm;
  import core_ctrl_pkg::*;

  localparam int C_ALUREG = 0, C_ALUIMM = 1, C_BR = 2, C_JALR = 3, C_JAL = 4,
                 C_AUIPC = 5, C_LUI = 6, C_LOAD = 7, C_STORE = 8, C_SYS = 9, C_NONE = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic [31:0] instr_data = '0;
  logic        isALUreg, isALUimm, isBranch, isJALR, isJAL, isAUIPC, isLUI, isLoad, isStore, isSYSTEM;
  logic [4:0]  rdId;
  logic [31:0] Bimm, Jimm, jalr_target;
  logic        take_branch;
  logic        instr_read_enable;
  logic [6:0]  instr_addr;
  logic [31:0] ir, pc, instret;
  logic        rf_write_enable, mem_req, mem_we, halted;
  logic [1:0]  wb_sel;
  logic [2:0]  state;

  core_control_fsm #(.IMEM_AWIDTH(7), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .isALUreg(isALUreg), .isALUimm(isALUimm), .isBranch(isBranch), .isJALR(isJALR),
    .isJAL(isJAL), .isAUIPC(isAUIPC), .isLUI(isLUI), .isLoad(isLoad), .isStore(isStore),
    .isSYSTEM(isSYSTEM), .rdId(rdId), .Bimm(Bimm), .Jimm(Jimm), .jalr_target(jalr_target),
    .take_branch(take_branch), .mem_ready(mem_ready), .instr_data(instr_data),
    .instr_read_enable(instr_read_enable), .instr_addr(instr_addr), .ir(ir), .pc(pc),
    .rf_write_enable(rf_write_enable), .wb_sel(wb_sel), .mem_req(mem_req), .mem_we(mem_we),
    .halted(halted), .instret(instret), .state(state)
  );

  always #5 clock = ~clock;

  logic [31:0] imem [128];
  always @(posedge clock) if (instr_read_enable) instr_data <= imem[instr_addr];

  function automatic int cls_of(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return C_ALUREG;
      7'b0010011: return C_ALUIMM;
      7'b1100011: return C_BR;
      7'b1100111: return C_JALR;
      7'b1101111: return C_JAL;
      7'b0010111: return C_AUIPC;
      7'b0110111: return C_LUI;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1110011: return C_SYS;
      default:    return C_NONE;
    endcase
  endfunction
  function automatic logic [31:0] bimm_of(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] jimm_of(input logic [31:0] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction
  // Stand-in for rs1+Iimm with a fixed rs1 of 0x100.
  function automatic logic [31:0] jt_of(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]} + 32'h100;
  endfunction

  assign isALUreg    = cls_of(ir) == C_ALUREG;
  assign isALUimm    = cls_of(ir) == C_ALUIMM;
  assign isBranch    = cls_of(ir) == C_BR;
  assign isJALR      = cls_of(ir) == C_JALR;
  assign isJAL       = cls_of(ir) == C_JAL;
  assign isAUIPC     = cls_of(ir) == C_AUIPC;
  assign isLUI       = cls_of(ir) == C_LUI;
  assign isLoad      = cls_of(ir) == C_LOAD;
  assign isStore     = cls_of(ir) == C_STORE;
  assign isSYSTEM    = cls_of(ir) == C_SYS;
  assign rdId        = ir[11:7];
  assign Bimm        = bimm_of(ir);
  assign Jimm        = jimm_of(ir);
  assign jalr_target = jt_of(ir);
  assign take_branch = ir[12];

  typedef struct {
    logic        mr;
    logic        ren;
    logic [6:0]  addr;
    logic [31:0] ir, pc, inst;
    logic        rfwe;
    logic [1:0]  wb;
    logic        mreq, mwe, halt;
    logic [2:0]  st;
  } rec_t;

  rec_t q[$];
  logic [31:0] m_pc, m_ir, m_inst;
  bit          m_halted;
  bit          dir_mode;
  int          dir_wait;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  logic        s_ren, s_rfwe, s_mreq, s_mwe, s_halt;
  logic [6:0]  s_addr;
  logic [31:0] s_ir, s_pc, s_inst;
  logic [1:0]  s_wb;
  logic [2:0]  s_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic spur(input bit is_fetch);
    if (dir_mode) return is_fetch;
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic logic [31:0] model_next(input int c, input logic [31:0] w, input logic [31:0] p);
    logic [31:0] t;
    case (c)
      C_JAL:   t = p + jimm_of(w);
      C_JALR:  t = jt_of(w);
      C_BR:    t = w[12] ? p + bimm_of(w) : p + 32'd4;
      default: t = p + 32'd4;
    endcase
    return t & 32'hFFFF_FFFC;
  endfunction

  // Appends the expected per-cycle outputs of the next instruction.
  task automatic plan_one();
    rec_t r;
    logic [31:0] w;
    int c, n;
    r = '{mr: 1'b0, ren: 1'b0, addr: m_pc[8:2], ir: m_ir, pc: m_pc, inst: m_inst,
          rfwe: 1'b0, wb: WB_ALU, mreq: 1'b0, mwe: 1'b0, halt: 1'b0, st: FETCH};
    if (m_halted) begin
      r.halt = 1'b1; r.st = HALT; r.mr = spur(1'b0);
      q.push_back(r);
      return;
    end
    w = imem[m_pc[8:2]];
    c = cls_of(w);
    r.ren = 1'b1; r.mr = spur(1'b1);
    q.push_back(r);
    r.ren = 1'b0; r.st = WAIT_INSTR; r.mr = spur(1'b0);
    q.push_back(r);
    m_ir = w; r.ir = w; r.st = EXECUTE; r.mr = spur(1'b0);
    if (c == C_SYS) begin
      q.push_back(r);
      m_halted = 1'b1;
      return;
    end else if (c == C_LOAD || c == C_STORE) begin
      r.mreq = 1'b1; r.mwe = (c == C_STORE);
      q.push_back(r);
      n = dir_mode ? dir_wait : $urandom_range(0, 4);
      r.mreq = 1'b0; r.mwe = 1'b0; r.wb = WB_MEM; r.st = WAIT_MEM; r.mr = 1'b0;
      repeat (n) q.push_back(r);
      r.mr = 1'b1; r.rfwe = (c == C_LOAD) && (w[11:7] != 5'd0);
      q.push_back(r);
    end else begin
      r.rfwe = (c inside {C_ALUREG, C_ALUIMM, C_LUI, C_AUIPC, C_JAL, C_JALR}) && (w[11:7] != 5'd0);
      r.wb = (c == C_LUI) ? WB_IMM : (c == C_JAL || c == C_JALR) ? WB_PC4 : WB_ALU;
      q.push_back(r);
    end
    m_pc = model_next(c, w, m_pc);
    m_inst = m_inst + 32'd1;
  endtask

  // Called at a falling edge: drive, sample 1 time unit later, compare, advance.
  task automatic step();
    rec_t r;
    if (q.size() == 0) plan_one();
    r = q.pop_front();
    mem_ready = r.mr;
    #1;
    s_ren = instr_read_enable; s_addr = instr_addr; s_ir = ir; s_pc = pc; s_inst = instret;
    s_rfwe = rf_write_enable; s_wb = wb_sel; s_mreq = mem_req; s_mwe = mem_we;
    s_halt = halted; s_st = state;
    chk("instr_read_enable", {31'd0, s_ren}, {31'd0, r.ren});
    chk("instr_addr", {25'd0, s_addr}, {25'd0, r.addr});
    chk("ir", s_ir, r.ir);
    chk("pc", s_pc, r.pc);
    chk("instret", s_inst, r.inst);
    chk("rf_write_enable", {31'd0, s_rfwe}, {31'd0, r.rfwe});
    chk("wb_sel", {30'd0, s_wb}, {30'd0, r.wb});
    chk("mem_req", {31'd0, s_mreq}, {31'd0, r.mreq});
    chk("mem_we", {31'd0, s_mwe}, {31'd0, r.mwe});
    chk("halted", {31'd0, s_halt}, {31'd0, r.halt});
    chk("state", {29'd0, s_st}, {29'd0, r.st});
    cyc++;
    @(negedge clock);
  endtask

  task automatic at(input int c);
    while (cyc <= c) step();
  endtask

  task automatic do_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_state", {29'd0, state}, {29'd0, FETCH});
    chk("rst_strobes", {27'd0, instr_read_enable, rf_write_enable, mem_req, mem_we, halted}, 32'h0);
    chk("rst_wb_sel", {30'd0, wb_sel}, {30'd0, WB_ALU});
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    q.delete();
    m_pc = 32'h0; m_ir = 32'h0; m_inst = 32'h0; m_halted = 1'b0;
    cyc = 0;
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 99);
    if (k < 18)      w[6:0] = 7'b0110011;
    else if (k < 36) w[6:0] = 7'b0010011;
    else if (k < 46) w[6:0] = 7'b1100011;
    else if (k < 51) w[6:0] = 7'b1100111;
    else if (k < 56) w[6:0] = 7'b1101111;
    else if (k < 63) w[6:0] = 7'b0010111;
    else if (k < 70) w[6:0] = 7'b0110111;
    else if (k < 80) w[6:0] = 7'b0000011;
    else if (k < 90) w[6:0] = 7'b0100011;
    else if (k < 92) w[6:0] = 7'b1110011;
    else             w[6:0] = 7'b1111111;
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    @(negedge clock);

    // addi / nop / taken bne back to 0
    dir_mode = 1'b1; dir_wait = 0;
    fill_nops();
    imem[0] = 32'h0010_0093;
    imem[1] = 32'h0000_0013;
    imem[2] = 32'hFE00_1CE3;
    do_reset();
    at(0);
    chk("a_c0_ren", {31'd0, s_ren}, 32'd1);
    chk("a_c0_addr", {25'd0, s_addr}, 32'd0);
    at(2);
    chk("a_c2_ir", s_ir, 32'h0010_0093);
    chk("a_c2_rfwe", {31'd0, s_rfwe}, 32'd1);
    chk("a_c2_wb", {30'd0, s_wb}, {30'd0, WB_ALU});
    at(3);
    chk("a_c3_pc", s_pc, 32'd4);
    chk("a_c3_instret", s_inst, 32'd1);
    at(5);
    chk("a_rd0_rfwe", {31'd0, s_rfwe}, 32'd0);
    at(6);
    chk("a_rd0_pc", s_pc, 32'd8);
    at(8);
    chk("a_br_rfwe", {31'd0, s_rfwe}, 32'd0);
    at(9);
    chk("a_taken_pc", s_pc, 32'd0);
    chk("a_taken_instret", s_inst, 32'd3);

    // beq not taken, jalr, slow lw, ebreak
    fill_nops();
    imem[2] = 32'hFE00_0CE3;
    imem[3] = 32'hF130_00E7;
    imem[4] = 32'h0002_A283;
    imem[5] = 32'h0010_0073;
    dir_wait = 3;
    do_reset();
    at(9);
    chk("b_nt_pc", s_pc, 32'd12);
    at(11);
    chk("b_jalr_rfwe", {31'd0, s_rfwe}, 32'd1);
    chk("b_jalr_wb", {30'd0, s_wb}, {30'd0, WB_PC4});
    at(12);
    chk("b_jalr_pc", s_pc, 32'h10);
    at(14);
    chk("b_lw_req", {30'd0, s_mreq, s_mwe}, 32'b10);
    at(15);
    chk("b_lw_req_once", {31'd0, s_mreq}, 32'd0);
    at(18);
    chk("b_lw_rfwe", {31'd0, s_rfwe}, 32'd1);
    chk("b_lw_wb", {30'd0, s_wb}, {30'd0, WB_MEM});
    at(19);
    chk("b_lw_pc", s_pc, 32'h14);
    chk("b_lw_instret", s_inst, 32'd5);
    at(41);
    chk("b_halted", {31'd0, s_halt}, 32'd1);
    chk("b_halt_pc", s_pc, 32'h14);

    // lw that never completes, abandoned by reset
    fill_nops();
    imem[0] = 32'h0002_A283;
    dir_wait = 10;
    do_reset();
    at(4);
    chk("c_wait_state", {29'd0, s_st}, {29'd0, WAIT_MEM});
    do_reset();

    // randomized programs, some with a reset mid-run
    dir_mode = 1'b0;
    for (int e = 0; e < 6; e++) begin
      int rst_at;
      for (int i = 0; i < 128; i++) imem[i] = rand_word();
      do_reset();
      rst_at = (e % 2 == 1) ? $urandom_range(20, 150) : -1;
      for (int k = 0; k < 220; k++) begin
        if (k == rst_at) do_reset();
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
